// File: rtl/tone_to_scancode_tx.sv
// Plays a note index as a PS/2-style scan-code stream: make, hold, F0 break, code, gap.
// Optional typematic re-strobe during MAKE is enabled by defining TONE_TX_REPEAT_EN.
module tone_to_scancode_tx #(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned BRK_CYCLES    = 4,
    parameter int unsigned GAP_CYCLES    = 16,
    parameter int unsigned REPEAT_PERIOD = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [3:0] med_ma,
    input  logic [3:0] low_ma,
    output logic [7:0] data,
    output logic       data_stb,
    output logic       busy,
    output logic       err
);

    localparam int unsigned MAX_HB  = (HOLD_CYCLES > BRK_CYCLES) ? HOLD_CYCLES : BRK_CYCLES;
    localparam int unsigned MAX_HBG = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_HBG > REPEAT_PERIOD) ? MAX_HBG : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StMake,
        StBrkF0,
        StBrkCode,
        StGap
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       code_r;
    logic [7:0]       lut_code;
    logic             lut_ok;

`ifdef TONE_TX_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_PERIOD) + 1;
    logic [REP_W-1:0] rep_r;
`endif

    // A note comes from exactly one range; both ranges set at once has no scan code.
    always_comb begin
        lut_ok   = 1'b1;
        lut_code = 8'h00;
        if (med_ma == 4'd0) begin
            case (low_ma)
                4'd0:    lut_code = 8'h29;
                4'd1:    lut_code = 8'h58;
                4'd2:    lut_code = 8'h1C;
                4'd3:    lut_code = 8'h1B;
                4'd4:    lut_code = 8'h23;
                4'd5:    lut_code = 8'h2B;
                4'd6:    lut_code = 8'h34;
                4'd7:    lut_code = 8'h33;
                4'd8:    lut_code = 8'h2C;
                4'd9:    lut_code = 8'h43;
                4'd10:   lut_code = 8'h44;
                4'd11:   lut_code = 8'h54;
                4'd12:   lut_code = 8'h5D;
                4'd13:   lut_code = 8'h66;
                default: lut_ok   = 1'b0;
            endcase
        end else if (low_ma == 4'd0) begin
            case (med_ma)
                4'd1:    lut_code = 8'h3B;
                4'd2:    lut_code = 8'h42;
                4'd3:    lut_code = 8'h4B;
                4'd4:    lut_code = 8'h4C;
                4'd5:    lut_code = 8'h52;
                4'd6:    lut_code = 8'h5A;
                4'd7:    lut_code = 8'h71;
                4'd8:    lut_code = 8'h69;
                4'd9:    lut_code = 8'h7A;
                4'd10:   lut_code = 8'h6C;
                default: lut_ok   = 1'b0;
            endcase
        end else begin
            lut_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= StIdle;
            cnt_r      <= '0;
            code_r     <= 8'h00;
            data       <= 8'h00;
            data_stb   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            note_ready <= 1'b1;
`ifdef TONE_TX_REPEAT_EN
            rep_r      <= '0;
`endif
        end else begin
            data_stb <= 1'b0;
            err      <= 1'b0;
            case (state_r)
                StIdle: begin
                    if (note_valid && note_ready) begin
                        if (lut_ok) begin
                            state_r    <= StMake;
                            code_r     <= lut_code;
                            data       <= lut_code;
                            data_stb   <= 1'b1;
                            busy       <= 1'b1;
                            note_ready <= 1'b0;
                            cnt_r      <= CNT_W'(HOLD_CYCLES);
`ifdef TONE_TX_REPEAT_EN
                            rep_r      <= REP_W'(REPEAT_PERIOD);
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StMake: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r  <= StBrkF0;
                        data     <= 8'hF0;
                        data_stb <= 1'b1;
                        cnt_r    <= CNT_W'(BRK_CYCLES);
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
`ifdef TONE_TX_REPEAT_EN
                        // Exit cycle is excluded by the branch above; F0 strobes there instead.
                        if (rep_r == REP_W'(1)) begin
                            data_stb <= 1'b1;
                            rep_r    <= REP_W'(REPEAT_PERIOD);
                        end else begin
                            rep_r <= rep_r - 1'b1;
                        end
`endif
                    end
                end
                StBrkF0: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r  <= StBrkCode;
                        data     <= code_r;
                        data_stb <= 1'b1;
                        cnt_r    <= CNT_W'(BRK_CYCLES);
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                StBrkCode: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= StGap;
                        data    <= 8'h00;
                        cnt_r   <= CNT_W'(GAP_CYCLES);
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_r    <= StIdle;
                        busy       <= 1'b0;
                        note_ready <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                    state_r    <= StIdle;
                    busy       <= 1'b0;
                    note_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_to_scancode_tx.sv
// Bench for tone_to_scancode_tx: table-driven notes, strobe scoreboard, reset and hold-valid cases.
module tb_tone_to_scancode_tx;

    localparam int unsigned HOLD  = 8;
    localparam int unsigned BRK   = 2;
    localparam int unsigned GAP   = 3;
    localparam int unsigned REP   = 3;
    localparam int unsigned TOTAL = HOLD + 2 * BRK + GAP;

    logic       clk = 1'b0;
    logic       rst;
    logic       note_valid;
    logic       note_ready;
    logic [3:0] med_ma;
    logic [3:0] low_ma;
    logic [7:0] data;
    logic       data_stb;
    logic       busy;
    logic       err;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] stb_q[$];
    int   err_pend = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        logic [3:0] med;
        logic [3:0] low;
        bit         ok;
        logic [7:0] code;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    tone_to_scancode_tx #(
        .HOLD_CYCLES  (HOLD),
        .BRK_CYCLES   (BRK),
        .GAP_CYCLES   (GAP),
        .REPEAT_PERIOD(REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .med_ma    (med_ma),
        .low_ma    (low_ma),
        .data      (data),
        .data_stb  (data_stb),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_stb(input int i);
        bit s;
        s = (i == 0) || (i == int'(HOLD)) || (i == int'(HOLD + BRK));
`ifdef TONE_TX_REPEAT_EN
        if (i > 0 && i < int'(HOLD) && (i % int'(REP)) == 0) s = 1'b1;
`endif
        return s;
    endfunction

    function automatic logic [7:0] exp_data(input int i, input logic [7:0] c);
        if (i < int'(HOLD)) return c;
        if (i < int'(HOLD + BRK)) return 8'hF0;
        if (i < int'(HOLD + 2 * BRK)) return c;
        return 8'h00;
    endfunction

    function automatic int exp_count();
        int n = 0;
        for (int i = 0; i < int'(TOTAL); i++) if (exp_stb(i)) n++;
        return n;
    endfunction

    task automatic push_exp(input logic [7:0] c);
        for (int i = 0; i < int'(TOTAL); i++) if (exp_stb(i)) stb_q.push_back(exp_data(i, c));
    endtask

    // Scoreboard: every strobe must match the next expected byte.
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_stb) begin
                checks++;
                if (stb_q.size() == 0) begin
                    errors++;
                    $display("FAIL stb_unexpected: got strobe with data %0h, none expected at %0t",
                             data, $time);
                end else begin
                    logic [7:0] e;
                    e = stb_q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL stb_byte: got %0h expected %0h at %0t", data, e, $time);
                    end
                end
            end
            if (err) begin
                checks++;
                if (err_pend == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got err=1 expected 0 at %0t", $time);
                end else begin
                    err_pend--;
                end
            end
        end
    end

    // Called just after a negedge; returns just after the accepting posedge.
    task automatic send(input logic [3:0] m, input logic [3:0] l, input logic [7:0] c,
                        input bit ok, input bit keep);
        int t = 0;
        med_ma     = m;
        low_ma     = l;
        note_valid = 1'b1;
        if (ok) push_exp(c);
        else err_pend++;
        while (note_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (note_ready !== 1'b1) begin
            $display("FAIL accept_timeout: got note_ready=%b expected 1", note_ready);
            errors++;
            checks++;
        end
        @(posedge clk);
        #1;
        if (!keep) note_valid = 1'b0;
    endtask

    task automatic run_seq(input logic [7:0] c, input bit chg, input logic [3:0] m2,
                           input logic [3:0] l2, input logic [7:0] c2);
        int n = 0;
        for (int i = 0; i < int'(TOTAL); i++) begin
            @(negedge clk);
            check("seq_data", data, exp_data(i, c));
            check("seq_stb", data_stb, exp_stb(i));
            check("seq_busy", busy, 1);
            check("seq_ready", note_ready, 0);
            if (data_stb) n++;
            if (chg && i == 3) begin
                med_ma = m2;
                low_ma = l2;
                push_exp(c2);
            end
        end
        check("stb_count", n, exp_count());
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", note_ready, 1);
        check("idle_data", data, 0);
    endtask

    initial begin
        vecs[0] = '{4'd0,  4'd1,  1'b1, 8'h58};
        vecs[1] = '{4'd10, 4'd0,  1'b1, 8'h6C};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 8'h29};
        vecs[3] = '{4'd2,  4'd3,  1'b0, 8'h00};
        vecs[4] = '{4'd0,  4'd14, 1'b0, 8'h00};
        vecs[5] = '{4'd0,  4'd13, 1'b1, 8'h66};
        vecs[6] = '{4'd1,  4'd0,  1'b1, 8'h3B};
        vecs[7] = '{4'd11, 4'd0,  1'b0, 8'h00};
        vecs[8] = '{4'd0,  4'd7,  1'b1, 8'h33};
        vecs[9] = '{4'd7,  4'd0,  1'b1, 8'h71};

        rst        = 1'b1;
        note_valid = 1'b0;
        med_ma     = 4'd0;
        low_ma     = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_data", data, 0);
        check("rst_stb", data_stb, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", note_ready, 1);
        check("rst_err", err, 0);
        mon_en = 1'b1;

        foreach (vecs[k]) begin
            send(vecs[k].med, vecs[k].low, vecs[k].code, vecs[k].ok, 1'b0);
            if (vecs[k].ok) begin
                run_seq(vecs[k].code, 1'b0, 4'd0, 4'd0, 8'h00);
            end else begin
                @(negedge clk);
                check("err_pulse", err, 1);
                check("err_busy", busy, 0);
                check("err_data", data, 0);
                check("err_ready", note_ready, 1);
                @(negedge clk);
                check("err_clear", err, 0);
            end
        end

        // Valid held through the sequence; inputs change mid-MAKE and become the second note.
        send(4'd0, 4'd2, 8'h1C, 1'b1, 1'b1);
        run_seq(8'h1C, 1'b1, 4'd5, 4'd0, 8'h52);
        @(posedge clk);
        #1 note_valid = 1'b0;
        run_seq(8'h52, 1'b0, 4'd0, 4'd0, 8'h00);

        // Reset during BRK_F0 drops the sequence with no further break bytes.
        send(4'd3, 4'd0, 8'h4B, 1'b1, 1'b0);
        for (int i = 0; i <= int'(HOLD); i++) @(negedge clk);
        check("brk_f0_data", data, 8'hF0);
        mon_en = 1'b0;
        stb_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data", data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stb", data_stb, 0);
        check("mid_rst_ready", note_ready, 1);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_data", data, 0);
            check("post_rst_stb", data_stb, 0);
        end
        mon_en = 1'b1;

        send(4'd0, 4'd4, 8'h23, 1'b1, 1'b0);
        run_seq(8'h23, 1'b0, 4'd0, 4'd0, 8'h00);

        check("stb_q_drained", stb_q.size(), 0);
        check("err_drained", err_pend, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
